counter_seq_controller: RTL and testbench

Sequencing controller for the team's 4-bit sequence counters. It owns one 4-bit count register and decides which sequence that register steps through: mod-15 even, mod-15 odd, fixed custom, or plain mod-15 binary. It starts and stops counting, applies a programmable step prescaler, and accepts mode changes through a valid/ready handshake. Mode changes are applied only at a sequence wrap, so no partial sequence is ever emitted.

---
 rtl/counter_seq_controller.sv | 300 ++++++++++++++++++++++++++++++
 tb/tb_counter_seq_controller.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_seq_controller.sv
// -----------------------------------------------------------------------------
// counter_seq_controller
//
// Purpose:
//   Owns one 4-bit count register and steps it through one of four sequences:
//   mod-15 even, mod-15 odd, a fixed custom sequence, or plain mod-15 binary.
//   Counting is started/stopped by level inputs and paced by an 8-bit step
//   prescaler. Mode changes arrive through a valid/ready handshake. In IDLE
//   they apply at once; while running they are buffered and applied only at a
//   sequence wrap, so a partial sequence is never emitted.
//
// Parameters:
//   DEFAULT_MODE  mode loaded at reset (0 even, 1 odd, 2 custom, 3 binary)
//   STEP_DIV      count advances every STEP_DIV+1 cycles (0..255)
//
// Ports:
//   clk             in   rising-edge clock
//   rst             in   synchronous active-low reset
//   start           in   level; IDLE -> RUN when high and stop is low
//   stop            in   level; RUN/PEND -> IDLE, wins over everything else
//   mode_req[1:0]   in   requested mode
//   mode_req_valid  in   mode_req is valid this cycle
//   mode_req_ready  out  request can be accepted (decoded from state)
//   count[3:0]      out  current counter value (registered)
//   mode[1:0]       out  mode in effect (registered)
//   wrap            out  one-cycle pulse when count returns to F(mode)
//   busy            out  high in RUN or PEND (registered)
//   wrap_cnt[7:0]   out  only with WRAP_CNT_EN: saturating wrap counter,
//                        cleared whenever the mode changes value
//
// Build option:
//   WRAP_CNT_EN     define to add the wrap_cnt port and its register.
// -----------------------------------------------------------------------------
module counter_seq_controller #(
   parameter logic [1:0] DEFAULT_MODE = 2'd0,
   parameter int unsigned STEP_DIV    = 0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       stop,
   input  logic [1:0] mode_req,
   input  logic       mode_req_valid,
   output logic       mode_req_ready,
   output logic [3:0] count,
   output logic [1:0] mode,
   output logic       wrap,
   output logic       busy
`ifdef WRAP_CNT_EN
   ,
   output logic [7:0] wrap_cnt
`endif
);

   localparam logic [1:0] MODE_EVEN   = 2'd0;
   localparam logic [1:0] MODE_ODD    = 2'd1;
   localparam logic [1:0] MODE_CUSTOM = 2'd2;
   localparam logic [1:0] MODE_BIN    = 2'd3;

   localparam logic [7:0] STEP_DIV_C  = 8'(STEP_DIV);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_PEND = 2'd2
   } state_t;

   // ---------------------------------------------------------------------
   // Sequence helpers
   // ---------------------------------------------------------------------

   // First value F(m) of each sequence.
   function automatic logic [3:0] first_val(input logic [1:0] m);
      logic [3:0] r;
      case (m)
         MODE_EVEN:   r = 4'd0;
         MODE_ODD:    r = 4'd1;
         MODE_CUSTOM: r = 4'd3;
         MODE_BIN:    r = 4'd0;
         default:     r = 4'd0;
      endcase
      return r;
   endfunction

   // Last value L(m) of each sequence.
   function automatic logic [3:0] last_val(input logic [1:0] m);
      logic [3:0] r;
      case (m)
         MODE_EVEN:   r = 4'd14;
         MODE_ODD:    r = 4'd13;
         MODE_CUSTOM: r = 4'd6;
         MODE_BIN:    r = 4'd14;
         default:     r = 4'd14;
      endcase
      return r;
   endfunction

   // Membership of c in the sequence of mode m.
   function automatic logic is_member(input logic [1:0] m, input logic [3:0] c);
      logic r;
      case (m)
         MODE_EVEN:   r = ~c[0];
         MODE_ODD:    r = c[0] & (c != 4'd15);
         MODE_CUSTOM: begin
            case (c)
               4'd3, 4'd7, 4'd1, 4'd12,
               4'd9, 4'd4, 4'd14, 4'd6: r = 1'b1;
               default:                 r = 1'b0;
            endcase
         end
         MODE_BIN:    r = (c != 4'd15);
         default:     r = 1'b0;
      endcase
      return r;
   endfunction

   // Successor of c within mode m; only used when c is a member and not L(m).
   function automatic logic [3:0] next_val(input logic [1:0] m, input logic [3:0] c);
      logic [3:0] r;
      case (m)
         MODE_EVEN:   r = c + 4'd2;
         MODE_ODD:    r = c + 4'd2;
         MODE_CUSTOM: begin
            case (c)
               4'd3:    r = 4'd7;
               4'd7:    r = 4'd1;
               4'd1:    r = 4'd12;
               4'd12:   r = 4'd9;
               4'd9:    r = 4'd4;
               4'd4:    r = 4'd14;
               4'd14:   r = 4'd6;
               default: r = 4'd3;
            endcase
         end
         MODE_BIN:    r = c + 4'd1;
         default:     r = c + 4'd1;
      endcase
      return r;
   endfunction

   // ---------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------
   state_t     state_q, state_d;
   logic [3:0] count_q, count_d;
   logic [1:0] mode_q, mode_d;
   logic       pend_valid_q, pend_valid_d;
   logic [1:0] pend_mode_q, pend_mode_d;
   logic [7:0] presc_q, presc_d;
   logic       wrap_q, wrap_d;
   logic       busy_q, busy_d;
   logic       accept_s;
   logic       tick_s;

   // Ready depends on state only, so a requester never sees a combinational
   // path from its own valid.
   assign mode_req_ready = (state_q != ST_PEND);
   assign accept_s       = mode_req_valid & mode_req_ready;
   assign tick_s         = (presc_q == STEP_DIV_C);

   // Next-state, counting and handshake decode.
   always_comb begin
      state_d      = state_q;
      count_d      = count_q;
      mode_d       = mode_q;
      pend_valid_d = pend_valid_q;
      pend_mode_d  = pend_mode_q;
      presc_d      = presc_q;
      wrap_d       = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (accept_s) begin
               // Immediate switch; supersedes any request left over from a stop.
               mode_d       = mode_req;
               count_d      = first_val(mode_req);
               presc_d      = 8'd0;
               pend_valid_d = 1'b0;
            end else if (start && !stop && pend_valid_q) begin
               // Request kept across a stop: apply the mode now, the count
               // is reconciled on the first tick if it is not a member.
               mode_d       = pend_mode_q;
               pend_valid_d = 1'b0;
            end else begin
               mode_d       = mode_q;
            end

            if (start && !stop) begin
               state_d = ST_RUN;
               presc_d = 8'd0;
            end else begin
               state_d = ST_IDLE;
            end
         end

         ST_RUN, ST_PEND: begin
            if (stop) begin
               // Stop wins: count and prescaler hold, a request is retained.
               state_d = ST_IDLE;
               if (accept_s) begin
                  pend_valid_d = 1'b1;
                  pend_mode_d  = mode_req;
               end else begin
                  pend_valid_d = pend_valid_q;
               end
            end else begin
               if (accept_s) begin
                  pend_valid_d = 1'b1;
                  pend_mode_d  = mode_req;
                  state_d      = ST_PEND;
               end else begin
                  state_d      = state_q;
               end

               if (tick_s) begin
                  presc_d = 8'd0;
                  if ((state_q == ST_PEND) && (count_q == last_val(mode_q))) begin
                     mode_d       = pend_mode_q;
                     count_d      = first_val(pend_mode_q);
                     wrap_d       = 1'b1;
                     pend_valid_d = 1'b0;
                     state_d      = ST_RUN;
                  end else if (!is_member(mode_q, count_q) ||
                               (count_q == last_val(mode_q))) begin
                     count_d = first_val(mode_q);
                     wrap_d  = 1'b1;
                  end else begin
                     count_d = next_val(mode_q, count_q);
                  end
               end else begin
                  presc_d = presc_q + 8'd1;
               end
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   // Register bank with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= ST_IDLE;
         count_q      <= first_val(DEFAULT_MODE);
         mode_q       <= DEFAULT_MODE;
         pend_valid_q <= 1'b0;
         pend_mode_q  <= 2'd0;
         presc_q      <= 8'd0;
         wrap_q       <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         count_q      <= count_d;
         mode_q       <= mode_d;
         pend_valid_q <= pend_valid_d;
         pend_mode_q  <= pend_mode_d;
         presc_q      <= presc_d;
         wrap_q       <= wrap_d;
         busy_q       <= busy_d;
      end
   end

   assign count = count_q;
   assign mode  = mode_q;
   assign wrap  = wrap_q;
   assign busy  = busy_q;

`ifdef WRAP_CNT_EN
   logic [7:0] wrap_cnt_q, wrap_cnt_d;

   // Wrap counter next value; a mode change restarts the count even when it
   // coincides with the switch-over wrap.
   always_comb begin
      wrap_cnt_d = wrap_cnt_q;
      if (mode_d != mode_q) begin
         wrap_cnt_d = 8'd0;
      end else if (wrap_d && (wrap_cnt_q != 8'd255)) begin
         wrap_cnt_d = wrap_cnt_q + 8'd1;
      end else begin
         wrap_cnt_d = wrap_cnt_q;
      end
   end

   // Wrap counter register.
   always_ff @(posedge clk) begin
      if (!rst) begin
         wrap_cnt_q <= 8'd0;
      end else begin
         wrap_cnt_q <= wrap_cnt_d;
      end
   end

   assign wrap_cnt = wrap_cnt_q;
`endif

endmodule

// File: tb/tb_counter_seq_controller.sv
// -----------------------------------------------------------------------------
// tb_counter_seq_controller
//
// Directed bench for counter_seq_controller. dut0 runs with DEFAULT_MODE=0 and
// STEP_DIV=0 and carries most scenarios; dut1 runs with DEFAULT_MODE=1 and
// STEP_DIV=2 to exercise the prescaler. Inputs change and outputs are
// sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_counter_seq_controller;

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   // dut0 stimulus / observation
   logic       rst, start, stop, valid;
   logic [1:0] mode_req;
   logic       ready, wrap, busy;
   logic [3:0] count;
   logic [1:0] mode;
`ifdef WRAP_CNT_EN
   logic [7:0] wrap_cnt, wrap_cnt1;
`endif

   // dut1 stimulus / observation
   logic       rst1, start1, stop1, valid1;
   logic [1:0] mode_req1;
   logic       ready1, wrap1, busy1;
   logic [3:0] count1;
   logic [1:0] mode1;

   int n_cmp = 0;
   int n_bad = 0;

   counter_seq_controller #(.DEFAULT_MODE(2'd0), .STEP_DIV(0)) dut0 (
      .clk(clk), .rst(rst), .start(start), .stop(stop),
      .mode_req(mode_req), .mode_req_valid(valid), .mode_req_ready(ready),
      .count(count), .mode(mode), .wrap(wrap), .busy(busy)
`ifdef WRAP_CNT_EN
      , .wrap_cnt(wrap_cnt)
`endif
   );

   counter_seq_controller #(.DEFAULT_MODE(2'd1), .STEP_DIV(2)) dut1 (
      .clk(clk), .rst(rst1), .start(start1), .stop(stop1),
      .mode_req(mode_req1), .mode_req_valid(valid1), .mode_req_ready(ready1),
      .count(count1), .mode(mode1), .wrap(wrap1), .busy(busy1)
`ifdef WRAP_CNT_EN
      , .wrap_cnt(wrap_cnt1)
`endif
   );

   task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b0; start = 1'b0; stop = 1'b0; valid = 1'b0; mode_req = 2'd0;
      rst1 = 1'b0; start1 = 1'b0; stop1 = 1'b0; valid1 = 1'b0; mode_req1 = 2'd0;
      step(); step();

      // Reset values
      chk_eq("rst_count", 32'(count), 32'd0);
      chk_eq("rst_mode", 32'(mode), 32'd0);
      chk_eq("rst_wrap", 32'(wrap), 32'd0);
      chk_eq("rst_busy", 32'(busy), 32'd0);
      chk_eq("rst_ready", 32'(ready), 32'd1);
      chk_eq("rst1_count", 32'(count1), 32'd1);
      chk_eq("rst1_mode", 32'(mode1), 32'd1);
`ifdef WRAP_CNT_EN
      chk_eq("rst_wcnt", 32'(wrap_cnt), 32'd0);
`endif
      rst = 1'b1;
      step();
      chk_eq("idle_count", 32'(count), 32'd0);

      // Even mode from start, full sequence and wrap
      start = 1'b1;
      step();
      chk_eq("start_busy", 32'(busy), 32'd1);
      chk_eq("start_count", 32'(count), 32'd0);
      start = 1'b0;
      for (int i = 1; i <= 7; i++) begin
         step();
         chk_eq("even_count", 32'(count), 32'(2 * i));
         chk_eq("even_nowrap", 32'(wrap), 32'd0);
      end
      step();
      chk_eq("even_wrap_count", 32'(count), 32'd0);
      chk_eq("even_wrap", 32'(wrap), 32'd1);
      step();
      chk_eq("even_after_wrap", 32'(count), 32'd2);
      chk_eq("even_wrap_low", 32'(wrap), 32'd0);

      // Pending request carried across a stop, applied on restart
      step();
      chk_eq("even_4", 32'(count), 32'd4);
      valid = 1'b1; mode_req = 2'd1;
      step();
      valid = 1'b0;
      chk_eq("pend_count", 32'(count), 32'd6);
      chk_eq("pend_ready", 32'(ready), 32'd0);
      chk_eq("pend_busy", 32'(busy), 32'd1);
      stop = 1'b1;
      step();
      stop = 1'b0;
      chk_eq("pstop_busy", 32'(busy), 32'd0);
      chk_eq("pstop_count", 32'(count), 32'd6);
      chk_eq("pstop_mode", 32'(mode), 32'd0);
      start = 1'b1;
      step();
      start = 1'b0;
      chk_eq("restart_mode", 32'(mode), 32'd1);
      chk_eq("restart_count", 32'(count), 32'd6);
      step();
      chk_eq("nonmember_load", 32'(count), 32'd1);
      chk_eq("nonmember_wrap", 32'(wrap), 32'd1);
      step();
      chk_eq("odd_next", 32'(count), 32'd3);
      stop = 1'b1;
      step();
      stop = 1'b0;
      chk_eq("stop3_count", 32'(count), 32'd3);

      // Idle request to binary, run, request custom at count 5
      valid = 1'b1; mode_req = 2'd3;
      step();
      valid = 1'b0;
      chk_eq("idle_req_mode", 32'(mode), 32'd3);
      chk_eq("idle_req_count", 32'(count), 32'd0);
      chk_eq("idle_req_nowrap", 32'(wrap), 32'd0);
      start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         step();
         chk_eq("bin_count", 32'(count), 32'(i));
      end
      chk_eq("bin_ready", 32'(ready), 32'd1);
      valid = 1'b1; mode_req = 2'd2;
      step();
      chk_eq("sw_count6", 32'(count), 32'd6);
      chk_eq("sw_ready", 32'(ready), 32'd0);
      mode_req = 2'd0;  // held valid while not ready must be ignored
      for (int i = 7; i <= 9; i++) begin
         step();
         chk_eq("sw_hold_count", 32'(count), 32'(i));
         chk_eq("sw_hold_ready", 32'(ready), 32'd0);
      end
      valid = 1'b0;
      for (int i = 10; i <= 14; i++) begin
         step();
         chk_eq("sw_tail_count", 32'(count), 32'(i));
         chk_eq("sw_tail_mode", 32'(mode), 32'd3);
      end
      step();
      chk_eq("sw_count", 32'(count), 32'd3);
      chk_eq("sw_wrap", 32'(wrap), 32'd1);
      chk_eq("sw_mode", 32'(mode), 32'd2);
      chk_eq("sw_ready_back", 32'(ready), 32'd1);
      step();
      chk_eq("cust_7", 32'(count), 32'd7);
      chk_eq("cust_nowrap", 32'(wrap), 32'd0);
      step();
      chk_eq("cust_1", 32'(count), 32'd1);
      step();
      chk_eq("cust_12", 32'(count), 32'd12);
      chk_eq("cust_mode", 32'(mode), 32'd2);

      // start+stop together in IDLE
      stop = 1'b1;
      step();
      chk_eq("stop12_busy", 32'(busy), 32'd0);
      start = 1'b1;
      step();
      chk_eq("ss_busy", 32'(busy), 32'd0);
      chk_eq("ss_count", 32'(count), 32'd12);
      start = 1'b0; stop = 1'b0;
      step();
      chk_eq("ss_hold", 32'(count), 32'd12);

      // Stop during RUN at count 8
      valid = 1'b1; mode_req = 2'd3;
      step();
      valid = 1'b0;
      start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         step();
      end
      chk_eq("run_at8", 32'(count), 32'd8);
      stop = 1'b1;
      step();
      stop = 1'b0;
      chk_eq("stop8_count", 32'(count), 32'd8);
      chk_eq("stop8_busy", 32'(busy), 32'd0);
      step();
      chk_eq("stop8_hold", 32'(count), 32'd8);

      // Idle request mode 1 at count 4
      valid = 1'b1; mode_req = 2'd0;
      step();
      valid = 1'b0;
      start = 1'b1;
      step();
      start = 1'b0;
      step(); step();
      stop = 1'b1;
      step();
      stop = 1'b0;
      chk_eq("idle4_count", 32'(count), 32'd4);
      valid = 1'b1; mode_req = 2'd1;
      step();
      valid = 1'b0;
      chk_eq("idle4_req_count", 32'(count), 32'd1);
      chk_eq("idle4_req_mode", 32'(mode), 32'd1);
      chk_eq("idle4_req_nowrap", 32'(wrap), 32'd0);
      chk_eq("idle4_req_busy", 32'(busy), 32'd0);

      // Reset mid-PEND discards the request
      start = 1'b1;
      step();
      start = 1'b0;
      valid = 1'b1; mode_req = 2'd2;
      step();
      valid = 1'b0;
      chk_eq("rp_count", 32'(count), 32'd3);
      chk_eq("rp_ready", 32'(ready), 32'd0);
      step();
      rst = 1'b0;
      step();
      rst = 1'b1;
      chk_eq("rp_rst_count", 32'(count), 32'd0);
      chk_eq("rp_rst_mode", 32'(mode), 32'd0);
      chk_eq("rp_rst_wrap", 32'(wrap), 32'd0);
      chk_eq("rp_rst_busy", 32'(busy), 32'd0);
      chk_eq("rp_rst_ready", 32'(ready), 32'd1);
`ifdef WRAP_CNT_EN
      chk_eq("rp_rst_wcnt", 32'(wrap_cnt), 32'd0);
`endif
      start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 1; i <= 7; i++) begin
         step();
      end
      step();
      chk_eq("rp_wrap_count", 32'(count), 32'd0);
      chk_eq("rp_wrap", 32'(wrap), 32'd1);
      chk_eq("rp_wrap_mode", 32'(mode), 32'd0);

      // dut1: odd mode, STEP_DIV=2 -> each value held 3 cycles
      rst1 = 1'b1;
      step();
      start1 = 1'b1;
      step();
      start1 = 1'b0;
      chk_eq("div_start", 32'(count1), 32'd1);
      for (int k = 1; k <= 21; k++) begin
         step();
         chk_eq("div_count", 32'(count1), 32'(1 + 2 * ((k / 3) % 7)));
         chk_eq("div_wrap", 32'(wrap1), 32'((k == 21) ? 1 : 0));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
